// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: two-entry skid buffer between EXECUTE and MEMORY with
// valid/ready handshake and branch-taken select for the fetch PC mux.
module ex_mem_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_add_result,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_rdata2,
    input  logic [REG_W-1:0]  ex_write_reg,
    input  logic [1:0]        ex_wb,
    input  logic [2:0]        ex_m,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_add_result,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic              mem_zero,
    output logic [DATA_W-1:0] mem_rdata2,
    output logic [REG_W-1:0]  mem_write_reg,
    output logic [1:0]        mem_wb,
    output logic [2:0]        mem_m,
    output logic              mem_pcsrc
);

    typedef struct packed {
        logic [DATA_W-1:0] add_result;
        logic [DATA_W-1:0] alu_result;
        logic              zero;
        logic [DATA_W-1:0] rdata2;
        logic [REG_W-1:0]  write_reg;
        logic [1:0]        wb;
        logic [2:0]        m;
    } bundle_t;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } state_e;

    state_e  state_q, state_d;
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    bundle_t ex_bundle;
    logic    xfer_in, xfer_out;

    assign ex_bundle = '{
        add_result: ex_add_result,
        alu_result: ex_alu_result,
        zero:       ex_zero,
        rdata2:     ex_rdata2,
        write_reg:  ex_write_reg,
        wb:         ex_wb,
        m:          ex_m
    };

    // Both handshake outputs come straight from state, so mem_ready never reaches ex_ready.
    assign ex_ready  = (state_q != StTwo);
    assign mem_valid = (state_q != StEmpty);
    assign xfer_in   = ex_valid & ex_ready;
    assign xfer_out  = mem_valid & mem_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (xfer_in) begin
                        main_d  = ex_bundle;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (xfer_in && xfer_out) begin
                        main_d = ex_bundle;
                    end else if (xfer_out) begin
                        state_d = StEmpty;
                    end else if (xfer_in) begin
                        skid_d  = ex_bundle;
                        state_d = StTwo;
                    end
                end
                StTwo: begin
                    if (xfer_out) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign mem_add_result = main_q.add_result;
    assign mem_alu_result = main_q.alu_result;
    assign mem_zero       = main_q.zero;
    assign mem_rdata2     = main_q.rdata2;
    assign mem_write_reg  = main_q.write_reg;
    // Control fields are masked so a stale payload after flush cannot write or branch.
    assign mem_wb         = mem_valid ? main_q.wb : 2'b00;
    assign mem_m          = mem_valid ? main_q.m : 3'b000;
    assign mem_pcsrc      = mem_valid & main_q.m[2] & main_q.zero;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed scenarios plus randomized traffic against a
// two-deep FIFO reference model.
module tb_ex_mem_reg;

    typedef struct packed {
        logic [31:0] add;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] rdata2;
        logic [4:0]  wr;
        logic [1:0]  wb;
        logic [2:0]  m;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_add_result = '0;
    logic [31:0] ex_alu_result = '0;
    logic        ex_zero = 1'b0;
    logic [31:0] ex_rdata2 = '0;
    logic [4:0]  ex_write_reg = '0;
    logic [1:0]  ex_wb = '0;
    logic [2:0]  ex_m = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_add_result;
    logic [31:0] mem_alu_result;
    logic        mem_zero;
    logic [31:0] mem_rdata2;
    logic [4:0]  mem_write_reg;
    logic [1:0]  mem_wb;
    logic [2:0]  mem_m;
    logic        mem_pcsrc;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    bundle_t     q[$];

    always #5 clk = ~clk;

    ex_mem_reg #(
        .DATA_W(32),
        .REG_W (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_add_result (ex_add_result),
        .ex_alu_result (ex_alu_result),
        .ex_zero       (ex_zero),
        .ex_rdata2     (ex_rdata2),
        .ex_write_reg  (ex_write_reg),
        .ex_wb         (ex_wb),
        .ex_m          (ex_m),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_add_result(mem_add_result),
        .mem_alu_result(mem_alu_result),
        .mem_zero      (mem_zero),
        .mem_rdata2    (mem_rdata2),
        .mem_write_reg (mem_write_reg),
        .mem_wb        (mem_wb),
        .mem_m         (mem_m),
        .mem_pcsrc     (mem_pcsrc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.add    = $urandom;
        b.alu    = $urandom;
        b.zero   = 1'($urandom_range(0, 1));
        b.rdata2 = $urandom;
        b.wr     = 5'($urandom_range(0, 31));
        b.wb     = 2'($urandom_range(0, 3));
        b.m      = 3'($urandom_range(0, 7));
        return b;
    endfunction

    function automatic bundle_t mk(input logic [31:0] add, input logic zero, input logic [2:0] m);
        bundle_t b;
        b      = rand_bundle();
        b.add  = add;
        b.zero = zero;
        b.m    = m;
        return b;
    endfunction

    // Outputs against the model's view: q holds the bundles MEM has not yet consumed.
    task automatic check_model();
        check("ex_ready", 32'(ex_ready), 32'(q.size() < 2));
        check("mem_valid", 32'(mem_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("mem_add_result", mem_add_result, q[0].add);
            check("mem_alu_result", mem_alu_result, q[0].alu);
            check("mem_zero", 32'(mem_zero), 32'(q[0].zero));
            check("mem_rdata2", mem_rdata2, q[0].rdata2);
            check("mem_write_reg", 32'(mem_write_reg), 32'(q[0].wr));
            check("mem_wb", 32'(mem_wb), 32'(q[0].wb));
            check("mem_m", 32'(mem_m), 32'(q[0].m));
            check("mem_pcsrc", 32'(mem_pcsrc), 32'(q[0].m[2] & q[0].zero));
        end else begin
            check("mem_wb_idle", 32'(mem_wb), 32'd0);
            check("mem_m_idle", 32'(mem_m), 32'd0);
            check("mem_pcsrc_idle", 32'(mem_pcsrc), 32'd0);
        end
    endtask

    // One cycle: check at negedge, drive inputs, then advance the model past the next posedge.
    task automatic step(input logic v, input logic r, input logic f, input bundle_t b);
        bit accept, consume;
        @(negedge clk);
        check_model();
        ex_valid      = v;
        mem_ready     = r;
        flush         = f;
        ex_add_result = b.add;
        ex_alu_result = b.alu;
        ex_zero       = b.zero;
        ex_rdata2     = b.rdata2;
        ex_write_reg  = b.wr;
        ex_wb         = b.wb;
        ex_m          = b.m;
        if (f) begin
            q.delete();
        end else begin
            consume = (q.size() > 0) && r;
            accept  = v && (q.size() < 2);
            if (consume) void'(q.pop_front());
            if (accept) q.push_back(b);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bundle_t b;
        // Reset state
        #2;
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_add", mem_add_result, 32'd0);
        check("rst_pcsrc", 32'(mem_pcsrc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single-cycle latency, then streaming
        step(1, 1, 0, mk(32'h0022_00BB, 1'b0, 3'b000));
        after_edge();
        check("t1_valid", 32'(mem_valid), 32'd1);
        check("t1_add", mem_add_result, 32'h0022_00BB);
        for (int i = 0; i < 8; i++) step(1, 1, 0, mk(32'(100 + i), 1'b0, 3'b000));
        step(0, 1, 0, rand_bundle());
        step(0, 1, 0, rand_bundle());

        // 2: stall fills skid, C held off, drain in order
        step(1, 0, 0, mk(32'h1, 1'b0, 3'b000));
        step(1, 0, 0, mk(32'h2, 1'b0, 3'b000));
        after_edge();
        check("t2_front_a", mem_add_result, 32'h1);
        check("t2_ready_low", 32'(ex_ready), 32'd0);
        step(1, 0, 0, mk(32'h3, 1'b0, 3'b000));
        step(1, 1, 0, mk(32'h3, 1'b0, 3'b000));
        after_edge();
        check("t2_front_b", mem_add_result, 32'h2);
        step(1, 1, 0, mk(32'h3, 1'b0, 3'b000));
        after_edge();
        check("t2_front_c", mem_add_result, 32'h3);
        step(0, 1, 0, rand_bundle());
        step(0, 1, 0, rand_bundle());

        // 3: branch taken select
        step(1, 1, 0, mk(32'h40, 1'b1, 3'b100));
        after_edge();
        check("t3_pcsrc_taken", 32'(mem_pcsrc), 32'd1);
        step(1, 1, 0, mk(32'h44, 1'b0, 3'b100));
        after_edge();
        check("t3_pcsrc_not", 32'(mem_pcsrc), 32'd0);
        step(0, 1, 0, rand_bundle());

        // 4: flush while full, with a same-cycle ex bundle
        b    = mk(32'h50, 1'b1, 3'b111);
        b.wb = 2'b11;
        step(1, 0, 0, b);
        step(1, 0, 0, mk(32'h51, 1'b1, 3'b111));
        after_edge();
        check("t4_full", 32'(ex_ready), 32'd0);
        step(1, 0, 1, mk(32'h52, 1'b1, 3'b111));
        after_edge();
        check("t4_valid", 32'(mem_valid), 32'd0);
        check("t4_wb", 32'(mem_wb), 32'd0);
        check("t4_m", 32'(mem_m), 32'd0);
        check("t4_ready", 32'(ex_ready), 32'd1);
        step(0, 1, 0, rand_bundle());
        step(0, 1, 0, rand_bundle());

        // 5: asynchronous reset mid-cycle while full
        step(1, 0, 0, mk(32'h60, 1'b1, 3'b111));
        step(1, 0, 0, mk(32'h61, 1'b1, 3'b111));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_valid", 32'(mem_valid), 32'd0);
        check("t5_ready", 32'(ex_ready), 32'd1);
        check("t5_pcsrc", 32'(mem_pcsrc), 32'd0);
        check("t5_add", mem_add_result, 32'd0);
        q.delete();
        ex_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, mk(32'h70, 1'b0, 3'b000));
        after_edge();
        check("t5_latency", 32'(mem_valid), 32'd1);
        check("t5_add_after", mem_add_result, 32'h70);

        // 6: random traffic
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 63) == 0), rand_bundle());
        end
        step(0, 1, 0, rand_bundle());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
